sfifo_axi_wdrain: RTL and testbench
===================================

Name: sfifo_axi_wdrain

Overview:
- Read-side consumer for the team's synchronous FIFO (sfifo).
- Pops the FIFO with `rnext` and converts the stored words into an AXI4 write-data (W channel) burst with correct `wlast`.
- Each burst is launched by a length command from the AW-side controller.
- Sits between the write-data FIFO and the MIG/AXI slave port.

Parameters:
- DW, 32, data width; equals the FIFO SFIFODW (or DW+DW/8 when the strobe feature is on).
- LENW, 8, width of the burst length field; AXI awlen encoding, beats-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_len  in  LENW  beats-1 of the burst.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- rqempty  in  1  FIFO empty flag.
- rdata  in  DW(+DW/8)  FIFO head word; first-word-fall-through, valid whenever rqempty=0.
- rnext  out  1  pop strobe to FIFO; head advances next edge.
- wvalid  out  1  AXI W valid.
- wready  in  1  AXI W ready.
- wdata  out  DW  AXI W data.
- wstrb  out  DW/8  AXI W byte strobes.
- wlast  out  1  final beat of burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after last beat handshake.

Behaviour:
- Reset (async, rst=1): state IDLE.
  - All outputs 0 except cmd_ready=1 (as decoded in IDLE).
  - Counters and data register cleared.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. Goes to RUN when cmd_valid&cmd_ready; latches fetch_cnt=send_cnt=cmd_len.
  - RUN: cmd_ready=0, busy=1.
  - DONE: single cycle; done=1, busy=0; then IDLE.
- Fetch counter: fetch_rem flag is set on command accept and cleared after the pop of beat cmd_len.
- Output stage is a single register (wdata/wstrb/wlast/wvalid).
  - slot_free = ~wvalid | wready.
  - rnext = RUN & fetch_rem & ~rqempty & slot_free.
- Register load: on rnext the register loads rdata and sets wvalid=1.
  - wlast=1 iff fetch_cnt==0 at that pop; otherwise fetch_cnt decrements.
- Handshake: if wvalid&wready and no pop the same cycle, wvalid clears next edge.
- wdata/wstrb/wlast hold stable while wvalid=1 and wready=0 (AXI rule). No combinational path from wready to wvalid.
- Latency:
  - First beat: wvalid rises 1 cycle after the accept cycle, if the FIFO is non-empty.
  - Full throughput: 1 beat per clock when the FIFO is non-empty and wready=1.
- send_cnt decrements on each wvalid&wready. The handshake with wlast=1 moves RUN->DONE; done pulses the following cycle.
- Boundaries:
  - FIFO underrun mid-burst: wvalid drops and the burst resumes when rqempty falls; no bubble beat is sent.
  - cmd_len=0: single beat, wlast=1 on it.
  - cmd_len=2^LENW-1: 2^LENW beats, counter stops at 0, no wrap.
  - rnext is never asserted after the last pop; the next burst's data stays in the FIFO.
  - cmd_valid during RUN or DONE is ignored (not acknowledged).
  - rst mid-burst: immediate abort, wvalid=0. FIFO pointers are owned by the FIFO's own reset; both share the system reset.

Optional Feature:
- SFIFO_WDRAIN_STRB_EN defined:
  - FIFO word is {strb[DW/8-1:0], data[DW-1:0]}.
  - wstrb = upper DW/8 bits of the loaded word; wdata = lower DW bits.
- Not defined:
  - FIFO word is data only; rdata width DW.
  - wstrb is a constant all-ones whenever wvalid=1, and 0 in reset.

Decomposition:
- Shared package sfifo_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default DW/LENW;
  - a strobe-width function DW/8.
- One sub-module, sfifo_wdrain_oreg: the output holding register with wvalid/wready, load/hold/clear logic. The top keeps the FSM, counters and rnext.

Test Plan:
- After reset, cmd_len=3 accepted, FIFO preloaded with 0x11,0x22,0x33,0x44, wready=1 -> wvalid high cycles 2-5, wdata 11/22/33/44, wlast only on 0x44, 4 rnext pulses, done pulse cycle 6.
- cmd_len=0 with one word 0xA5A5A5A5 -> single beat, wlast=1, done next cycle, FIFO empty, no extra rnext.
- cmd_len=3, wready toggles 1,0,0,1,... -> wdata/wlast stable while stalled; exactly 4 handshakes; no rnext while the register is full and wready=0.
- cmd_len=7 with the FIFO starting with 2 words, 6 more pushed 5 cycles later -> wvalid gap after beat 2, beats 3-8 follow, wlast on beat 8, never a beat with rqempty data.
- Assert rst for 1 cycle during beat 2 of a cmd_len=3 burst -> wvalid=0, busy=0 immediately; a new cmd_len=1 after reset runs normally.
- With SFIFO_WDRAIN_STRB_EN, FIFO word {4'b0011, 0xDEADBEEF} -> wstrb=4'b0011, wdata=0xDEADBEEF; without the macro -> wstrb=4'b1111.

Source files
------------

// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared types and defaults for the sfifo W-channel drain (SFIFO_WDRAIN_STRB_EN selects word layout)
package sfifo_pkg;

   localparam int DEF_DW   = 32;
   localparam int DEF_LENW = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wd_state_t;

   // Byte-strobe width for a given data width
   function automatic int strb_width(input int dw);
      return dw / 8;
   endfunction

   // Width of one FIFO word: strobes ride above the data when enabled
   function automatic int word_width(input int dw);
`ifdef SFIFO_WDRAIN_STRB_EN
      return dw + dw / 8;
`else
      return dw;
`endif
   endfunction

endpackage

// File: rtl/sfifo_axi_wdrain_if.sv
// rtl/sfifo_axi_wdrain_if.sv - command, FIFO read-side and AXI W signals of the drain
interface sfifo_axi_wdrain_if
   import sfifo_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int LENW = DEF_LENW
);
   localparam int SW = strb_width(DW);
   localparam int RW = word_width(DW);

   logic            cmd_valid;
   logic [LENW-1:0] cmd_len;
   logic            cmd_ready;
   logic            rqempty;
   logic [RW-1:0]   rdata;
   logic            rnext;
   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [SW-1:0]   wstrb;
   logic            wlast;
   logic            busy;
   logic            done;

   // The drain itself
   modport master (
      input  cmd_valid, cmd_len, rqempty, rdata, wready,
      output cmd_ready, rnext, wvalid, wdata, wstrb, wlast, busy, done
   );

   // The surroundings: AW controller, FIFO and AXI slave
   modport slave (
      output cmd_valid, cmd_len, rqempty, rdata, wready,
      input  cmd_ready, rnext, wvalid, wdata, wstrb, wlast, busy, done
   );

endinterface

// File: rtl/sfifo_wdrain_oreg.sv
// rtl/sfifo_wdrain_oreg.sv - single-entry W output holding register
module sfifo_wdrain_oreg #(
   parameter int DW = 32,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [DW-1:0] i_data,
   input  logic [SW-1:0] i_strb,
   input  logic          i_last,
   input  logic          i_ready,
   output logic          o_free,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic [SW-1:0] o_strb,
   output logic          o_last
);
   logic          r_valid;
   logic [DW-1:0] r_data;
   logic [SW-1:0] r_strb;
   logic          r_last;

   // Load on a pop, otherwise hold the payload; valid drops only on a handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_strb  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_strb  <= i_strb;
         r_last  <= i_last;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   // The slot can take a new word when empty or when its word leaves this cycle
   assign o_free  = ~r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_strb  = r_strb;
   assign o_last  = r_last;

endmodule

// File: rtl/sfifo_axi_wdrain.sv
// rtl/sfifo_axi_wdrain.sv - sfifo read-side to AXI4 W burst converter (SFIFO_WDRAIN_STRB_EN: strobes stored in FIFO)
module sfifo_axi_wdrain
   import sfifo_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int LENW = DEF_LENW
) (
   input  logic                clk,
   input  logic                rst,
   sfifo_axi_wdrain_if.master  bus
);
   localparam int SW = strb_width(DW);

   wd_state_t       r_state;
   wd_state_t       w_state_nxt;
   logic [LENW-1:0] r_fetch_cnt;
   logic [LENW-1:0] r_send_cnt;
   logic            r_fetch_rem;

   logic            w_run;
   logic            w_accept;
   logic            w_slot_free;
   logic            w_pop;
   logic            w_hs;
   logic            w_last_hs;
   logic            w_ld_last;
   logic [DW-1:0]   w_ld_data;
   logic [SW-1:0]   w_ld_strb;

`ifdef SFIFO_WDRAIN_STRB_EN
   assign w_ld_data = bus.rdata[DW-1:0];
   assign w_ld_strb = bus.rdata[DW+SW-1:DW];
`else
   assign w_ld_data = bus.rdata;
   assign w_ld_strb = '1;
`endif

   assign w_run     = (r_state == ST_RUN);
   assign w_accept  = bus.cmd_valid & bus.cmd_ready;
   assign w_pop     = w_run & r_fetch_rem & ~bus.rqempty & w_slot_free;
   assign w_hs      = bus.wvalid & bus.wready;
   assign w_ld_last = (r_fetch_cnt == '0);
   assign w_last_hs = w_run & w_hs & bus.wlast & (r_send_cnt == '0);
   assign bus.rnext = w_pop;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: burst starts on accept, ends on the handshake of the last beat
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last_hs) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      case (r_state)
         ST_IDLE: bus.cmd_ready = 1'b1;
         ST_RUN:  bus.busy      = 1'b1;
         ST_DONE: bus.done      = 1'b1;
         default: bus.cmd_ready = 1'b0;
      endcase
   end

   // Fetch and send counters; fetch stops at zero so a full-length burst never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= '0;
         r_send_cnt  <= '0;
         r_fetch_rem <= 1'b0;
      end else if (w_accept) begin
         r_fetch_cnt <= bus.cmd_len;
         r_send_cnt  <= bus.cmd_len;
         r_fetch_rem <= 1'b1;
      end else begin
         if (w_pop) begin
            if (w_ld_last) begin
               r_fetch_rem <= 1'b0;
            end else begin
               r_fetch_cnt <= r_fetch_cnt - LENW'(1);
            end
         end
         if (w_run && w_hs && (r_send_cnt != '0)) begin
            r_send_cnt <= r_send_cnt - LENW'(1);
         end
      end
   end

   sfifo_wdrain_oreg #(
      .DW (DW),
      .SW (SW)
   ) u_oreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_pop),
      .i_data  (w_ld_data),
      .i_strb  (w_ld_strb),
      .i_last  (w_ld_last),
      .i_ready (bus.wready),
      .o_free  (w_slot_free),
      .o_valid (bus.wvalid),
      .o_data  (bus.wdata),
      .o_strb  (bus.wstrb),
      .o_last  (bus.wlast)
   );

endmodule

// File: tb/tb_sfifo_axi_wdrain.sv
// tb/tb_sfifo_axi_wdrain.sv - directed bench for sfifo_axi_wdrain (SFIFO_WDRAIN_STRB_EN changes the strobe test)
module tb_sfifo_axi_wdrain;
   localparam int RW = sfifo_pkg::word_width(32);

   logic clk = 1'b0;
   logic rst = 1'b1;

   sfifo_axi_wdrain_if #(.DW(32), .LENW(8)) bus ();

   sfifo_axi_wdrain #(.DW(32), .LENW(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // FIFO model: first-word-fall-through head
   logic [RW-1:0] mem [64];
   int wp = 0;
   int rp = 0;
   assign bus.rqempty = (wp == rp);
   assign bus.rdata   = mem[rp[5:0]];

   int asserts = 0;
   int errors  = 0;

   int cyc = 0;
   int n_hs = 0, n_rnext = 0, n_done = 0, n_acc = 0, n_last = 0;
   int n_full_rnext = 0, n_stall_viol = 0, n_stall_cyc = 0;
   int acc_cyc = 0, done_cyc = 0;
   logic [31:0] beat_data [64];
   logic [3:0]  beat_strb [64];
   logic        beat_last [64];
   int          beat_cyc  [64];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   // Monitor: pops, beats, accepts, done pulses and stall stability
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.rnext) begin
         rp <= rp + 1;
         n_rnext <= n_rnext + 1;
         if (bus.wvalid && !bus.wready) n_full_rnext <= n_full_rnext + 1;
      end
      if (bus.wvalid && bus.wready) begin
         beat_data[n_hs] <= bus.wdata;
         beat_strb[n_hs] <= bus.wstrb;
         beat_last[n_hs] <= bus.wlast;
         beat_cyc[n_hs]  <= cyc;
         n_hs <= n_hs + 1;
         if (bus.wlast) n_last <= n_last + 1;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
         n_acc <= n_acc + 1;
         acc_cyc <= cyc;
      end
      if (bus.done) begin
         n_done <= n_done + 1;
         done_cyc <= cyc;
      end
      if (prev_stall && (!bus.wvalid || bus.wdata !== prev_data || bus.wlast !== prev_last))
         n_stall_viol <= n_stall_viol + 1;
      if (bus.wvalid && !bus.wready && !rst) n_stall_cyc <= n_stall_cyc + 1;
      prev_stall <= bus.wvalid && !bus.wready && !rst;
      prev_data  <= bus.wdata;
      prev_last  <= bus.wlast;
   end

   task automatic push(input logic [RW-1:0] w);
      mem[wp[5:0]] = w;
      wp = wp + 1;
   endtask

   task automatic wait_done(input int base_done, input string name);
      int k;
      k = 0;
      while (n_done == base_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      asserts++;
      if (n_done == base_done) begin
         errors++;
         $display("FAIL %s_timeout: done count %0d, required > %0d", name, n_done, base_done);
      end
   endtask

   task automatic test_reset;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.wready    = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      asserts++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b need 1", bus.cmd_ready); end
      asserts++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %b need 0", bus.wvalid); end
      asserts++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b need 00", bus.busy, bus.done); end
      asserts++; if (bus.rnext !== 1'b0) begin errors++; $display("FAIL rst_rnext: got %b need 0", bus.rnext); end
      asserts++; if (bus.wstrb !== 4'h0 || bus.wlast !== 1'b0 || bus.wdata !== 32'h0) begin
         errors++; $display("FAIL rst_payload: got strb=%h last=%b data=%h need 0/0/0", bus.wstrb, bus.wlast, bus.wdata); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int b, bd, br;
      logic [31:0] exp [4];
      exp = '{32'h11, 32'h22, 32'h33, 32'h44};
      b = n_hs; bd = n_done; br = n_rnext;
      for (int i = 0; i < 4; i++) push(RW'(exp[i]));
      bus.wready = 1'b1;
      @(negedge clk);
      asserts++; if (bus.rnext !== 1'b0) begin errors++; $display("FAIL idle_no_pop: got %b need 0", bus.rnext); end
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd3;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done(bd, "basic");
      asserts++; if (n_hs - b !== 4) begin errors++; $display("FAIL basic_beats: got %0d need 4", n_hs - b); end
      for (int i = 0; i < 4; i++) begin
         asserts++; if (beat_data[b+i] !== exp[i] || beat_last[b+i] !== (i == 3)) begin
            errors++; $display("FAIL basic_beat%0d: got %h/%b need %h/%b", i, beat_data[b+i], beat_last[b+i], exp[i], i == 3); end
      end
      asserts++; if (beat_cyc[b] !== acc_cyc + 2) begin errors++; $display("FAIL basic_first_lat: got %0d need %0d", beat_cyc[b] - acc_cyc, 2); end
      asserts++; if (beat_cyc[b+3] !== acc_cyc + 5) begin errors++; $display("FAIL basic_throughput: got %0d need %0d", beat_cyc[b+3] - acc_cyc, 5); end
      asserts++; if (done_cyc !== acc_cyc + 6) begin errors++; $display("FAIL basic_done_cyc: got %0d need %0d", done_cyc - acc_cyc, 6); end
      asserts++; if (n_rnext - br !== 4) begin errors++; $display("FAIL basic_rnext: got %0d need 4", n_rnext - br); end
      @(negedge clk);
      asserts++; if (bus.wvalid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         errors++; $display("FAIL basic_after: got v=%b b=%b r=%b need 0 0 1", bus.wvalid, bus.busy, bus.cmd_ready); end
   endtask

   task automatic test_len0;
      int b, bd, br;
      b = n_hs; bd = n_done; br = n_rnext;
      push(RW'(32'hA5A5A5A5));
      push(RW'(32'hBBBB0000));
      bus.wready = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done(bd, "len0");
      repeat (3) @(negedge clk);
      asserts++; if (n_hs - b !== 1) begin errors++; $display("FAIL len0_beats: got %0d need 1", n_hs - b); end
      asserts++; if (beat_data[b] !== 32'hA5A5A5A5 || beat_last[b] !== 1'b1) begin
         errors++; $display("FAIL len0_beat: got %h/%b need a5a5a5a5/1", beat_data[b], beat_last[b]); end
      asserts++; if (done_cyc !== beat_cyc[b] + 1) begin errors++; $display("FAIL len0_done: got %0d need %0d", done_cyc - beat_cyc[b], 1); end
      asserts++; if (n_rnext - br !== 1) begin errors++; $display("FAIL len0_rnext: got %0d need 1", n_rnext - br); end
      asserts++; if (wp - rp !== 1 || bus.rdata[31:0] !== 32'hBBBB0000) begin
         errors++; $display("FAIL len0_fifo_left: got %0d/%h need 1/bbbb0000", wp - rp, bus.rdata[31:0]); end
      wp = rp;
   endtask

   task automatic test_stall;
      int b, bd, br, bv, bf, bs, i;
      int pat [4];
      pat = '{1, 0, 0, 1};
      b = n_hs; bd = n_done; br = n_rnext; bv = n_stall_viol; bf = n_full_rnext; bs = n_stall_cyc;
      for (int k = 0; k < 4; k++) push(RW'(32'h100 + k));
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd3;
      bus.wready = pat[0][0];
      i = 0;
      while (n_done == bd && i < 100) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         i++;
         bus.wready = pat[i % 4][0];
      end
      asserts++; if (n_done == bd) begin errors++; $display("FAIL stall_timeout: done count %0d need > %0d", n_done, bd); end
      bus.wready = 1'b1;
      @(negedge clk);
      asserts++; if (n_hs - b !== 4) begin errors++; $display("FAIL stall_beats: got %0d need 4", n_hs - b); end
      for (int k = 0; k < 4; k++) begin
         asserts++; if (beat_data[b+k] !== 32'h100 + k || beat_last[b+k] !== (k == 3)) begin
            errors++; $display("FAIL stall_beat%0d: got %h/%b need %h/%b", k, beat_data[b+k], beat_last[b+k], 32'h100 + k, k == 3); end
      end
      asserts++; if (n_stall_cyc - bs == 0) begin errors++; $display("FAIL stall_seen: got 0 stall cycles need >0"); end
      asserts++; if (n_stall_viol - bv !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes need 0", n_stall_viol - bv); end
      asserts++; if (n_full_rnext - bf !== 0) begin errors++; $display("FAIL stall_pop_full: got %0d need 0", n_full_rnext - bf); end
      asserts++; if (n_rnext - br !== 4) begin errors++; $display("FAIL stall_rnext: got %0d need 4", n_rnext - br); end
   endtask

   task automatic test_underrun;
      int b, bd, ba, bl;
      b = n_hs; bd = n_done; ba = n_acc; bl = n_last;
      push(RW'(32'h201));
      push(RW'(32'h202));
      bus.wready = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd7;
      @(posedge clk);
      for (int i = 1; i <= 5; i++) @(negedge clk);
      asserts++; if (bus.wvalid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL underrun_gap: got v=%b busy=%b need 0 1", bus.wvalid, bus.busy); end
      bus.cmd_valid = 1'b0;
      for (int k = 3; k <= 8; k++) push(RW'(32'h200 + k));
      wait_done(bd, "underrun");
      asserts++; if (n_hs - b !== 8) begin errors++; $display("FAIL underrun_beats: got %0d need 8", n_hs - b); end
      for (int k = 0; k < 8; k++) begin
         asserts++; if (beat_data[b+k] !== 32'h201 + k) begin
            errors++; $display("FAIL underrun_beat%0d: got %h need %h", k, beat_data[b+k], 32'h201 + k); end
      end
      asserts++; if (beat_last[b+7] !== 1'b1 || n_last - bl !== 1) begin
         errors++; $display("FAIL underrun_last: got %b/%0d need 1/1", beat_last[b+7], n_last - bl); end
      asserts++; if (beat_cyc[b+2] - beat_cyc[b+1] !== 3) begin
         errors++; $display("FAIL underrun_resume: got %0d need 3", beat_cyc[b+2] - beat_cyc[b+1]); end
      asserts++; if (beat_cyc[b+7] !== acc_cyc + 11) begin
         errors++; $display("FAIL underrun_end: got %0d need 11", beat_cyc[b+7] - acc_cyc); end
      asserts++; if (n_acc - ba !== 1) begin errors++; $display("FAIL run_cmd_ignored: got %0d accepts need 1", n_acc - ba); end
   endtask

   task automatic test_reset_mid;
      int b, bd;
      for (int k = 1; k <= 4; k++) push(RW'(32'h300 + k));
      bus.wready = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd3;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      asserts++; if (bus.wvalid !== 1'b1 || bus.wdata !== 32'h302) begin
         errors++; $display("FAIL midrst_pre: got %b/%h need 1/00000302", bus.wvalid, bus.wdata); end
      rst = 1'b1;
      #1;
      asserts++; if (bus.wvalid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wlast !== 1'b0) begin
         errors++; $display("FAIL midrst_abort: got v=%b b=%b r=%b l=%b need 0 0 1 0", bus.wvalid, bus.busy, bus.cmd_ready, bus.wlast); end
      @(negedge clk);
      rst = 1'b0;
      wp = rp;
      @(negedge clk);
      b = n_hs; bd = n_done;
      push(RW'(32'h401));
      push(RW'(32'h402));
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done(bd, "midrst");
      asserts++; if (n_hs - b !== 2) begin errors++; $display("FAIL midrst_beats: got %0d need 2", n_hs - b); end
      asserts++; if (beat_data[b] !== 32'h401 || beat_data[b+1] !== 32'h402 || beat_last[b] !== 1'b0 || beat_last[b+1] !== 1'b1) begin
         errors++; $display("FAIL midrst_data: got %h/%b %h/%b need 401/0 402/1", beat_data[b], beat_last[b], beat_data[b+1], beat_last[b+1]); end
   endtask

   task automatic test_strb;
      int b, bd;
      logic [3:0] exp_strb;
      b = n_hs; bd = n_done;
`ifdef SFIFO_WDRAIN_STRB_EN
      push({4'b0011, 32'hDEADBEEF});
      exp_strb = 4'b0011;
`else
      push(32'hDEADBEEF);
      exp_strb = 4'b1111;
`endif
      bus.wready = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done(bd, "strb");
      asserts++; if (beat_data[b] !== 32'hDEADBEEF || beat_strb[b] !== exp_strb) begin
         errors++; $display("FAIL strb_beat: got %h/%b need deadbeef/%b", beat_data[b], beat_strb[b], exp_strb); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_len0;
      test_stall;
      test_underrun;
      test_reset_mid;
      test_strb;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
      $finish;
   end

endmodule
